// File: rtl/register_file_if.sv
// Bus bundle for the MIPS general-purpose register file: one write port
// driven by write-back and two read ports serving the decode stage.
// The master side drives requests; the register file is the slave.
interface register_file_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);

  logic                     register_write_enable;
  logic [ADDRESS_WIDTH-1:0] register_write_address;
  logic [DATA_WIDTH-1:0]    register_write_data;

  logic                     register_read_enable_a;
  logic [ADDRESS_WIDTH-1:0] register_read_address_a;
  logic [DATA_WIDTH-1:0]    register_read_data_a;

  logic                     register_read_enable_b;
  logic [ADDRESS_WIDTH-1:0] register_read_address_b;
  logic [DATA_WIDTH-1:0]    register_read_data_b;

  modport master (
    output register_write_enable,
    output register_write_address,
    output register_write_data,
    output register_read_enable_a,
    output register_read_address_a,
    input  register_read_data_a,
    output register_read_enable_b,
    output register_read_address_b,
    input  register_read_data_b
  );

  modport slave (
    input  register_write_enable,
    input  register_write_address,
    input  register_write_data,
    input  register_read_enable_a,
    input  register_read_address_a,
    output register_read_data_a,
    input  register_read_enable_b,
    input  register_read_address_b,
    output register_read_data_b
  );

endinterface

// File: rtl/register_file.sv
// 32 x 32-bit general-purpose register file for the 5-stage MIPS core.
// Two combinational read ports (A/B) for decode, one registered write port
// for write-back. Register $0 is hardwired to zero.
// Optional feature: define REGISTER_FILE_BYPASS_EN to forward the write-back
// value to a read port that targets the register being written in the same
// cycle, closing the WB->ID hazard inside the register file.
module register_file #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int REGISTER_COUNT = 32
) (
  input logic           clock,
  input logic           reset,
  register_file_if.slave bus
);

  logic [DATA_WIDTH-1:0] entries [REGISTER_COUNT];
  logic                  write_commit;

  // A write only lands when reset is low and the target is not $0.
  always_comb begin
    write_commit = 1'b0;
    if (!reset && bus.register_write_enable && (bus.register_write_address != '0)) begin
      write_commit = 1'b1;
    end
  end

  // Storage: synchronous clear on reset, otherwise commit the write-back value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGISTER_COUNT; i++) begin
        entries[i] <= '0;
      end
    end else if (write_commit) begin
      entries[bus.register_write_address] <= bus.register_write_data;
    end
  end

  // Port A operand: reset, disable and $0 force zero before any storage lookup.
  always_comb begin
    bus.register_read_data_a = '0;
    if (reset || !bus.register_read_enable_a) begin
      bus.register_read_data_a = '0;
    end else if (bus.register_read_address_a == '0) begin
      bus.register_read_data_a = '0;
`ifdef REGISTER_FILE_BYPASS_EN
    end else if (write_commit && (bus.register_read_address_a == bus.register_write_address)) begin
      bus.register_read_data_a = bus.register_write_data;
`endif
    end else begin
      bus.register_read_data_a = entries[bus.register_read_address_a];
    end
  end

  // Port B operand: same rules as port A, fully independent of it.
  always_comb begin
    bus.register_read_data_b = '0;
    if (reset || !bus.register_read_enable_b) begin
      bus.register_read_data_b = '0;
    end else if (bus.register_read_address_b == '0) begin
      bus.register_read_data_b = '0;
`ifdef REGISTER_FILE_BYPASS_EN
    end else if (write_commit && (bus.register_read_address_b == bus.register_write_address)) begin
      bus.register_read_data_b = bus.register_write_data;
`endif
    end else begin
      bus.register_read_data_b = entries[bus.register_read_address_b];
    end
  end

endmodule
